// File: rtl/activation_stage_pkg.sv
// Shared constants, lookup tables and FSM encoding for the activation stage.
// Values are Q3.4 signed fixed point, one byte per lane.
package activation_stage_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned Q_INT_BITS  = 3;
  localparam int unsigned Q_FRAC_BITS = 4;
  localparam int unsigned MAG_W       = DATA_W - 1;
  localparam int unsigned SEG_W       = 3;
  localparam int unsigned FRAC_W      = Q_FRAC_BITS;
  localparam int unsigned N_SEG       = 8;

  localparam logic ACT_RELU = 1'b0;
  localparam logic ACT_TANH = 1'b1;

  localparam logic [DATA_W-1:0] MAG_SAT = 8'd127;

  // Piecewise-linear tanh: one segment per integer step of |x|.
  localparam logic [DATA_W-1:0] INTERCEPT [N_SEG] =
    '{8'd0, 8'd12, 8'd15, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16};
  localparam logic [DATA_W-1:0] SLOPE [N_SEG] =
    '{8'd12, 8'd3, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } act_state_e;

  // Unsigned tanh magnitude for a saturated |x| split into segment and fraction.
  function automatic logic [DATA_W-1:0] tanh_mag(input logic [SEG_W-1:0]  seg,
                                                 input logic [FRAC_W-1:0] frac);
    logic [DATA_W-1:0] prod;
    prod     = DATA_W'(SLOPE[seg] * {4'd0, frac});
    tanh_mag = DATA_W'(INTERCEPT[seg] + (prod >> Q_FRAC_BITS));
  endfunction

endpackage

// File: rtl/activation_stage_lane.sv
// One lane of the activation datapath: S1 decomposes |x|, S2 forms the result.
module activation_lane
  import activation_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              beat_i,
  input  logic              s1_valid_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic              mask_i,
  input  logic              type_i,
  output logic [DATA_W-1:0] y_o
);

  logic              sign_q, sign_d;
  logic [MAG_W-1:0]  mag_q, mag_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic              mask_q, type_q;
  logic [DATA_W-1:0] y_q, y_d;
  logic [DATA_W-1:0] abs_c;
  logic [DATA_W-1:0] tanh_m_c;

  // S1 decode: saturate |x| so that -128 maps to 127.
  always_comb begin
    sign_d = x_i[DATA_W-1];
    abs_c  = sign_d ? DATA_W'(~x_i + 8'd1) : x_i;
    mag_d  = (abs_c > MAG_SAT) ? MAG_W'(MAG_SAT) : abs_c[MAG_W-1:0];
    seg_d  = mag_d[MAG_W-1 -: SEG_W];
    frac_d = mag_d[FRAC_W-1:0];
  end

  // S2 result select.
  always_comb begin
    y_d      = '0;
    tanh_m_c = tanh_mag(seg_q, frac_q);
    if (mask_q) begin
      if (type_q == ACT_RELU) begin
        y_d = sign_q ? '0 : {1'b0, mag_q};
      end else begin
        y_d = sign_q ? DATA_W'(~tanh_m_c + 8'd1) : tanh_m_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      sign_q <= 1'b0;
      mag_q  <= '0;
      seg_q  <= '0;
      frac_q <= '0;
      mask_q <= 1'b0;
      type_q <= ACT_RELU;
      y_q    <= '0;
    end else begin
      if (beat_i) begin
        sign_q <= sign_d;
        mag_q  <= mag_d;
        seg_q  <= seg_d;
        frac_q <= frac_d;
        mask_q <= mask_i;
        type_q <= type_i;
      end
      if (s1_valid_i) begin
        y_q <= y_d;
      end
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/activation_stage.sv
// Activation stage top: per-lane ReLU / tanh PWL with a 2-cycle pipe,
// combinational bypass when disabled, and a burst-completion FSM.
module activation_stage
  import activation_stage_pkg::*;
#(
  parameter int unsigned MAT_MUL_SIZE = 8,
  parameter int unsigned DWIDTH       = 8,
  parameter int unsigned MASK_WIDTH   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable_activation,
  input  logic                           activation_type,
  input  logic                           in_data_available,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data,
  input  logic [MASK_WIDTH-1:0]          validity_mask,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
  output logic                           out_data_available,
  output logic                           done_activation
);

  localparam int unsigned ROW_W = MAT_MUL_SIZE * DWIDTH;

  logic             clear_c;
  logic             beat_c;
  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [ROW_W-1:0] pipe_row_c;
  act_state_e       state_q, state_d;

  assign clear_c = ~enable_activation;
  assign beat_c  = enable_activation & in_data_available;

  for (genvar k = 0; k < MAT_MUL_SIZE; k++) begin : g_lane
    activation_lane u_lane (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (clear_c),
      .beat_i     (beat_c),
      .s1_valid_i (s1_valid_q),
      .x_i        (inp_data[k*DWIDTH +: DWIDTH]),
      .mask_i     (validity_mask[k]),
      .type_i     (activation_type),
      .y_o        (pipe_row_c[k*DWIDTH +: DWIDTH])
    );
  end

  // Valid pipe; a disabled stage flushes so a later enable starts empty.
  always_comb begin
    s1_valid_d = beat_c;
    s2_valid_d = s1_valid_q;
  end

  always_ff @(posedge clk) begin
    if (reset || clear_c) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst tracking; done releases in the same cycle a new beat shows up.
  always_comb begin
    state_d         = state_q;
    done_activation = 1'b0;
    if (!enable_activation) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_data_available) state_d = ST_BUSY;
        end
        ST_BUSY: begin
          if (!in_data_available) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (in_data_available) begin
            state_d = ST_BUSY;
          end else if (!s1_valid_q && !s2_valid_q) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (in_data_available) begin
            state_d = ST_BUSY;
          end else begin
            done_activation = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Bypass muxes.
  assign out_data           = enable_activation ? pipe_row_c : inp_data;
  assign out_data_available = enable_activation ? s2_valid_q : in_data_available;

endmodule

// File: tb/tb_activation_stage.sv
// Scoreboard bench for activation_stage: directed rows plus a random stream.
module tb_activation_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_activation;
  logic        activation_type;
  logic        in_data_available;
  logic [63:0] inp_data;
  logic [7:0]  validity_mask;
  logic [63:0] out_data;
  logic        out_data_available;
  logic        done_activation;

  typedef struct {
    logic [63:0] data;
    int          cyc;
    string       tag;
  } sb_t;

  sb_t sb[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  int relu_in  [8] = '{5, -3, 0, 127, -128, 1, -1, 64};
  int relu_exp [8] = '{5, 0, 0, 127, 0, 1, 0, 64};
  int tanh_in  [8] = '{8, -24, 64, -128, 0, 16, 33, -4};
  int tanh_exp [8] = '{6, -13, 16, -16, 0, 12, 15, -3};
  int ic_tab   [8] = '{0, 12, 15, 16, 16, 16, 16, 16};
  int sl_tab   [8] = '{12, 3, 1, 0, 0, 0, 0, 0};

  activation_stage dut (
    .clk                (clk),
    .reset              (reset),
    .enable_activation  (enable_activation),
    .activation_type    (activation_type),
    .in_data_available  (in_data_available),
    .inp_data           (inp_data),
    .validity_mask      (validity_mask),
    .out_data           (out_data),
    .out_data_available (out_data_available),
    .done_activation    (done_activation)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pack_row(input int v [8]);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = 8'(v[k]);
    return r;
  endfunction

  function automatic int model_lane(input int x, input logic t, input logic m);
    int a, mm;
    if (!m) return 0;
    if (!t) return (x < 0) ? 0 : x;
    a = (x < 0) ? -x : x;
    if (a > 127) a = 127;
    mm = ic_tab[a / 16] + (sl_tab[a / 16] * (a % 16)) / 16;
    return (x < 0) ? -mm : mm;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic t, input logic [7:0] m,
                      input logic [63:0] e, input string tag);
    step();
    inp_data          = d;
    activation_type   = t;
    validity_mask     = m;
    in_data_available = 1'b1;
    sb.push_back('{e, cyc, tag});
  endtask

  task automatic quiet();
    step();
    in_data_available = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 30 && !(sb.size() == 0 && done_activation); i++) step();
    check_eq({tag, "_drained"}, 64'(sb.size()), 64'd0);
    check_eq({tag, "_done"}, 64'(done_activation), 64'd1);
  endtask

  // Output monitor: pop the oldest expectation and check data and latency.
  always @(negedge clk) begin
    if (!reset && enable_activation && out_data_available) begin
      if (sb.size() == 0) begin
        check_eq("spurious_out", 64'(out_data_available), 64'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check_eq(e.tag, out_data, e.data);
        check_eq({e.tag, "_latency"}, 64'(cyc - e.cyc), 64'd2);
        check_eq({e.tag, "_done_low"}, 64'(done_activation), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          xs [8];
    int          ys [8];
    logic        t;
    logic [7:0]  m;
    logic [63:0] pat;

    reset = 1'b1; enable_activation = 1'b1; activation_type = 1'b0;
    in_data_available = 1'b0; inp_data = '0; validity_mask = 8'hFF;
    repeat (3) step();
    reset = 1'b0;
    check_eq("reset_out_valid", 64'(out_data_available), 64'd0);
    check_eq("reset_out_data", out_data, 64'd0);
    check_eq("reset_done", 64'(done_activation), 64'd0);

    send(pack_row(relu_in), 1'b0, 8'hFF, pack_row(relu_exp), "relu");
    quiet();
    wait_done("relu");

    send(pack_row(tanh_in), 1'b1, 8'hFF, pack_row(tanh_exp), "tanh");
    quiet();
    wait_done("tanh");

    send({8{8'd20}}, 1'b0, 8'h0F, 64'h00000000_14141414, "mask");
    quiet();
    wait_done("mask");

    for (int b = 0; b < 4; b++) begin
      send({8{8'hF0}}, 1'(b % 2), 8'hFF, (b % 2) ? {8{8'hF4}} : 64'd0, "stream");
    end
    quiet();
    wait_done("stream");

    // Random stream with random gaps, types and masks.
    for (int b = 0; b < 24; b++) begin
      t = 1'($urandom_range(0, 1));
      m = 8'($urandom_range(0, 255));
      for (int k = 0; k < 8; k++) begin
        xs[k] = int'($urandom_range(0, 255)) - 128;
        ys[k] = model_lane(xs[k], t, m[k]);
      end
      send(pack_row(xs), t, m, pack_row(ys), "random");
      if ($urandom_range(0, 2) == 0) quiet();
    end
    quiet();
    wait_done("random");

    // Bypass is combinational and never signals done.
    step();
    enable_activation = 1'b0;
    pat = 64'hA5_3C_00_FF_80_7F_12_E1;
    inp_data = pat;
    in_data_available = 1'b1;
    #1;
    check_eq("bypass_data", out_data, pat);
    check_eq("bypass_valid", 64'(out_data_available), 64'd1);
    check_eq("bypass_done", 64'(done_activation), 64'd0);
    in_data_available = 1'b0;
    #1;
    check_eq("bypass_idle_valid", 64'(out_data_available), 64'd0);
    step();
    enable_activation = 1'b1;
    #1;
    check_eq("reenable_empty_data", out_data, 64'd0);
    check_eq("reenable_empty_valid", 64'(out_data_available), 64'd0);

    // Reset one cycle after an accepted beat must discard it.
    step();
    inp_data = {8{8'd33}};
    activation_type = 1'b1;
    validity_mask = 8'hFF;
    in_data_available = 1'b1;
    step();
    in_data_available = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("post_reset_valid", 64'(out_data_available), 64'd0);
    end
    check_eq("post_reset_done", 64'(done_activation), 64'd0);
    check_eq("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/activation_stage.md
Name: activation_stage

Overview:
- Per-lane activation unit that sits directly downstream of the pooling stage.
- Consumes a MAT_MUL_SIZE-lane row of DWIDTH-bit signed values per beat and applies ReLU or a piecewise-linear tanh.
- Fixed 2-cycle pipeline latency when enabled; combinational pass-through when disabled.
- Signals completion of each burst to the top-level control FSM via done_activation.

Parameters:
- MAT_MUL_SIZE, 8, number of lanes per row.
- DWIDTH, 8, bits per lane; signed two's complement, Q3.4 fixed point.
- MASK_WIDTH, 8, width of validity_mask; equals MAT_MUL_SIZE.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- enable_activation  input  1  1 = apply activation; 0 = bypass.
- activation_type  input  1  0 = ReLU, 1 = tanh PWL; sampled with each input beat.
- in_data_available  input  1  inp_data valid this cycle.
- inp_data  input  MAT_MUL_SIZE*DWIDTH  row from the pooling stage; lane k occupies bits [k*DWIDTH +: DWIDTH].
- validity_mask  input  MASK_WIDTH  lane k forced to 0 at the output when bit k = 0; sampled with the beat.
- out_data  output  MAT_MUL_SIZE*DWIDTH  activated row.
- out_data_available  output  1  out_data valid this cycle.
- done_activation  output  1  level; burst complete.

Behaviour:
- Reset (synchronous, active-high):
  - Clears both pipeline valid bits and data registers to 0.
  - Clears done_activation and returns the FSM to IDLE.
  - Registered outputs read 0 in the cycle after reset is sampled.
  - Reset mid-burst discards all in-flight beats; no out_data_available is produced for them.
- Bypass (enable_activation = 0):
  - out_data = inp_data and out_data_available = in_data_available, combinationally.
  - done_activation = 0.
  - Pipeline registers are cleared, so a later enable starts empty.
- Pipeline (enable_activation = 1):
  - S1 registers per lane: sign, magnitude, segment index, fraction, mask bit, type; plus a valid bit.
  - S2 computes the result and registers it.
  - A beat accepted at cycle t appears at cycle t+2 with out_data_available = 1.
  - Back-to-back beats are accepted every cycle; there is no backpressure.
  - out_data holds its last value when out_data_available = 0.
- ReLU: y = x if x >= 0, else 0.
- Tanh PWL:
  - a = |x|, saturated to 127, so x = -128 gives a = 127.
  - seg = a[6:4]; frac = a[3:0].
  - m = INTERCEPT[seg] + ((SLOPE[seg] * frac) >> 4), using an unsigned 8-bit intermediate.
  - y = m if x >= 0, else -m.
  - INTERCEPT = {0, 12, 15, 16, 16, 16, 16, 16}.
  - SLOPE = {12, 3, 1, 0, 0, 0, 0, 0}.
  - Output range is -16..16; no further saturation is needed.
- Mask: a lane with mask bit 0 outputs 0 regardless of type.
- Burst FSM (only advances while enabled):
  - IDLE -> BUSY on in_data_available.
  - BUSY -> DRAIN on the first cycle with in_data_available = 0.
  - DRAIN -> DONE when both pipeline valids are 0.
  - DRAIN -> BUSY if a new beat arrives.
  - DONE: done_activation = 1; DONE -> BUSY on a new beat; done_activation drops in that same cycle.
  - Any state -> IDLE when enable_activation = 0.
- Enable deasserted mid-burst is illegal upstream. If it happens, the pipeline is flushed with no outputs for in-flight beats.
- activation_type changing between beats is legal. Each beat uses the type sampled with it.

Decomposition:
- Shared package: Q3.4 format constants, ACT_RELU = 0 and ACT_TANH = 1 encodings, INTERCEPT/SLOPE tables, FSM state encoding.
- One sub-module, activation_lane: per-lane S1/S2 datapath, instantiated MAT_MUL_SIZE times by generate.
- The top level holds the valid pipe, the FSM and the bypass muxes.

Test Plan:
- ReLU:
  - Stimulus: enable = 1, type = 0, mask = 0xFF, one beat with lanes {5, -3, 0, 127, -128, 1, -1, 64}.
  - Response: two cycles later out_data_available = 1 with lanes {5, 0, 0, 127, 0, 1, 0, 64}. done_activation rises once both pipeline valids have drained.
- Tanh:
  - Stimulus: type = 1, lanes {8, -24, 64, -128, 0, 16, 33, -4}.
  - Response: {6, -13, 16, -16, 0, 12, 15, -3}.
- Masking:
  - Stimulus: mask = 0x0F with all lanes = 20 and type = 0.
  - Response: lanes 0-3 = 20, lanes 4-7 = 0.
- Streaming:
  - Stimulus: 4 consecutive beats alternating type 0/1, each with every lane = -16.
  - Response: 4 consecutive output cycles with lanes {0, -12, 0, -12}. done_activation is low throughout and asserts after the pipe drains.
- Bypass and reset:
  - Stimulus: enable = 0 with a pattern on inp_data. Response: out_data = inp_data in the same cycle.
  - Stimulus: reset asserted one cycle after a beat is accepted with enable = 1. Response: no out_data_available and done_activation = 0.
